// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core constants and types for the register-file writeback path:
// default widths, register count and the round-robin pointer encoding.
package regfile_wb_arbiter_pkg;

    localparam int CORE_DATA_WIDTH = 32;
    localparam int CORE_ADDR_WIDTH = 5;
    localparam int NUM_REGS        = 32;

    // RR_FRESH reads back as "last grant = ex" but still hands priority to ex,
    // which is the only way both reset behaviours can hold at once.
    typedef enum logic [1:0] {
        RR_FRESH    = 2'd0,
        RR_LAST_EX  = 2'd1,
        RR_LAST_MEM = 2'd2
    } rr_state_t;

    typedef enum logic {
        SRC_EX  = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

    function automatic logic rr_prefer_mem(input rr_state_t st);
        return st == RR_LAST_EX;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter for the execute and load writeback requesters.
// Grants are combinational; the last-grant pointer moves only on a grant.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    req_ex,
    input  logic    req_mem,
    output logic    gnt_ex,
    output logic    gnt_mem,
    output wb_src_t grant_src,
    output wb_src_t last_grant
);

    rr_state_t state;
    rr_state_t state_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RR_FRESH;
        end else begin
            state <= state_next;
        end
    end

    // A grant always coincides with its request, so a grant is an accepted transfer.
    always_comb begin
        state_next = state;
        if (gnt_ex) begin
            state_next = RR_LAST_EX;
        end else if (gnt_mem) begin
            state_next = RR_LAST_MEM;
        end
    end

    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        gnt_ex     = 1'b0;
        gnt_mem    = 1'b0;
        last_grant = (state == RR_LAST_MEM) ? SRC_MEM : SRC_EX;
        if (!reset) begin
            if (req_ex && req_mem) begin
                if (rr_prefer_mem(state)) begin
                    gnt_mem = 1'b1;
                end else begin
                    gnt_ex = 1'b1;
                end
            end else begin
                gnt_ex  = req_ex;
                gnt_mem = req_mem;
            end
        end
        grant_src = gnt_mem ? SRC_MEM : SRC_EX;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register-file write port, plus the
// destination-reservation scoreboard used by issue for hazard checks.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = CORE_DATA_WIDTH,
    parameter int ADDR_WIDTH = CORE_ADDR_WIDTH
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_data_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_enable_o,
    input  logic                  rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o
);

    wb_src_t               grant_src;
    wb_src_t               last_grant;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;

    rr_arbiter2 u_rr_arbiter2 (
        .clk        (clk),
        .reset      (reset),
        .req_ex     (ex_valid_i),
        .req_mem    (mem_valid_i),
        .gnt_ex     (ex_ready_o),
        .gnt_mem    (mem_ready_o),
        .grant_src  (grant_src),
        .last_grant (last_grant)
    );

    always_comb begin
        accept   = ex_ready_o | mem_ready_o;
        sel_addr = (grant_src == SRC_MEM) ? mem_addr_i : ex_addr_i;
        sel_data = (grant_src == SRC_MEM) ? mem_data_i : ex_data_i;
    end

    // Address/data capture every accepted transfer, including writes to x0;
    // only the enable is suppressed for x0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_enable_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
        end else begin
            wr_enable_o <= accept && (sel_addr != '0);
            if (accept) begin
                wr_addr_o <= sel_addr;
                wr_data_o <= sel_data;
            end
        end
    end

    // Commit clears first, reservation sets second, so a same-edge re-reservation wins.
    always_comb begin
        pending_next = pending;
        if (wr_enable_o) begin
            pending_next[wr_addr_o] = 1'b0;
        end
        if (rsv_valid_i && (rsv_addr_i != '0)) begin
            pending_next[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    always_comb begin
        rs1_busy_o = (rs1_addr_i != '0) && pending[rs1_addr_i];
        rs2_busy_o = (rs2_addr_i != '0) && pending[rs2_addr_i];
    end

    grant_onehot: assert property (@(posedge clk) disable iff (reset)
        !(ex_ready_o && mem_ready_o));

    no_x0_commit: assert property (@(posedge clk) disable iff (reset)
        wr_enable_o |-> (wr_addr_o != '0));

    // Round-robin state is internal; last_grant is exposed only for observability.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == SRC_MEM);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised scoreboard bench for regfile_wb_arbiter: a driver applies stimulus
// and predicts commits from the arbitration/reservation rules; a monitor checks them.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DW = CORE_DATA_WIDTH;
    localparam int AW = CORE_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ex_valid_i = 1'b0;
    logic          ex_ready_o;
    logic [AW-1:0] ex_addr_i = '0;
    logic [DW-1:0] ex_data_i = '0;
    logic          mem_valid_i = 1'b0;
    logic          mem_ready_o;
    logic [AW-1:0] mem_addr_i = '0;
    logic [DW-1:0] mem_data_i = '0;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          wr_enable_o;
    logic          rsv_valid_i = 1'b0;
    logic [AW-1:0] rsv_addr_i = '0;
    logic [AW-1:0] rs1_addr_i = '0;
    logic [AW-1:0] rs2_addr_i = '0;
    logic          rs1_busy_o;
    logic          rs2_busy_o;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid_i  (ex_valid_i),
        .ex_ready_o  (ex_ready_o),
        .ex_addr_i   (ex_addr_i),
        .ex_data_i   (ex_data_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .wr_enable_o (wr_enable_o),
        .rsv_valid_i (rsv_valid_i),
        .rsv_addr_i  (rsv_addr_i),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_busy_o  (rs1_busy_o),
        .rs2_busy_o  (rs2_busy_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_wr_t;

    exp_wr_t exp_q[$];

    // Reference model: who won last (0 none since reset, 1 ex, 2 mem), which
    // registers are reserved, what the write port should be holding.
    bit            pending_m[NUM_REGS];
    int            last_winner;
    logic [AW-1:0] hold_addr_m;
    logic [DW-1:0] hold_data_m;
    bit            commit_v;
    logic [AW-1:0] commit_a;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        foreach (pending_m[i]) pending_m[i] = 1'b0;
        last_winner = 0;
        hold_addr_m = '0;
        hold_data_m = '0;
        commit_v    = 1'b0;
        commit_a    = '0;
    endtask

    // Called just after a rising edge; drives one cycle, checks, predicts, returns after the next edge.
    task automatic step(input bit exv, input logic [AW-1:0] exa, input logic [DW-1:0] exd,
                        input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input bit rv, input logic [AW-1:0] ra,
                        input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        bit            take_ex;
        bit            take_mem;
        logic [AW-1:0] acc_a;
        logic [DW-1:0] acc_d;
        ex_valid_i  = exv;  ex_addr_i  = exa; ex_data_i  = exd;
        mem_valid_i = mv;   mem_addr_i = ma;  mem_data_i = md;
        rsv_valid_i = rv;   rsv_addr_i = ra;
        rs1_addr_i  = q1;   rs2_addr_i = q2;
        @(negedge clk);
        take_ex  = exv && (!mv || last_winner != 1);
        take_mem = mv && (!exv || last_winner == 1);
        check("ex_ready", ex_ready_o, take_ex);
        check("mem_ready", mem_ready_o, take_mem);
        check("rs1_busy", rs1_busy_o, (q1 != 0) && pending_m[q1]);
        check("rs2_busy", rs2_busy_o, (q2 != 0) && pending_m[q2]);
        check("wr_addr_held", wr_addr_o, hold_addr_m);
        check("wr_data_held", wr_data_o, hold_data_m);
        acc_a = '0;
        acc_d = '0;
        if (take_ex || take_mem) begin
            acc_a = take_ex ? exa : ma;
            acc_d = take_ex ? exd : md;
            if (acc_a != 0) exp_q.push_back('{cyc + 1, acc_a, acc_d});
            hold_addr_m = acc_a;
            hold_data_m = acc_d;
            last_winner = take_ex ? 1 : 2;
        end
        if (commit_v) pending_m[commit_a] = 1'b0;
        if (rv && ra != 0) pending_m[ra] = 1'b1;
        commit_v = (take_ex || take_mem) && (acc_a != 0);
        commit_a = acc_a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        step(0, '0, '0, 0, '0, '0, 0, '0, q1, q2);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, NUM_REGS - 1));
    endfunction

    // Monitor: every negedge, the write port must match the head of the queue or be idle.
    initial begin
        exp_wr_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("wr_enable", wr_enable_o, 1'b1);
                check("wr_addr_commit", wr_addr_o, e.addr);
                check("wr_data_commit", wr_data_o, e.data);
            end else begin
                check("wr_enable_idle", wr_enable_o, 1'b0);
            end
        end
    end

    initial begin
        model_reset();
        ex_valid_i  = 1'b1;
        mem_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_enable", wr_enable_o, 1'b0);
        check("rst_wr_addr", wr_addr_o, '0);
        check("rst_wr_data", wr_data_o, '0);
        check("rst_ex_ready", ex_ready_o, 1'b0);
        check("rst_mem_ready", mem_ready_o, 1'b0);
        ex_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        reset       = 1'b0;

        // Both requesting straight out of reset: ex, mem, ex, mem.
        for (int i = 0; i < 4; i++) begin
            step(1, AW'(1), DW'(32'h1000 + i), 1, AW'(2), DW'(32'h2000 + i), 0, '0, '0, '0);
        end

        // Single ex request, then a load writing x0.
        step(1, AW'(5), 32'hDEADBEEF, 0, '0, '0, 0, '0, '0, '0);
        step(0, '0, '0, 1, AW'(0), 32'h12345678, 0, '0, '0, '0);
        idle('0, '0);

        // Reservation of x7 lives until the edge ending its commit cycle.
        step(0, '0, '0, 0, '0, '0, 1, AW'(7), AW'(7), '0);
        idle(AW'(7), '0);
        step(1, AW'(7), 32'h77777777, 0, '0, '0, 0, '0, AW'(7), '0);
        idle(AW'(7), '0);
        idle(AW'(7), '0);
        idle(AW'(7), '0);

        // Re-reserving x9 on the edge its commit clears keeps it busy.
        step(0, '0, '0, 0, '0, '0, 1, AW'(9), '0, AW'(9));
        step(0, '0, '0, 1, AW'(9), 32'h99999999, 0, '0, '0, AW'(9));
        step(0, '0, '0, 0, '0, '0, 1, AW'(9), '0, AW'(9));
        idle('0, AW'(9));
        idle('0, AW'(9));

        // Same destination from both units back to back.
        step(1, AW'(3), 32'hAAAA0003, 1, AW'(3), 32'hBBBB0003, 0, '0, AW'(3), '0);
        step(1, AW'(3), 32'hCCCC0003, 1, AW'(3), 32'hDDDD0003, 0, '0, AW'(3), '0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, rand_addr(), $urandom(),
                 $urandom_range(0, 1) == 1, rand_addr(), $urandom(),
                 $urandom_range(0, 2) == 0, rand_addr(), rand_addr(), rand_addr());
        end

        // Reset lands while an accepted write is on the port.
        step(1, AW'(3), 32'hA5A50003, 0, '0, '0, 1, AW'(12), AW'(12), AW'(3));
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        ex_valid_i  = 1'b1;
        mem_valid_i = 1'b1;
        #1;
        check("midrst_wr_enable", wr_enable_o, 1'b0);
        check("midrst_wr_addr", wr_addr_o, '0);
        check("midrst_wr_data", wr_data_o, '0);
        check("midrst_ex_ready", ex_ready_o, 1'b0);
        check("midrst_mem_ready", mem_ready_o, 1'b0);
        for (int a = 0; a < NUM_REGS; a++) begin
            rs1_addr_i = AW'(a);
            rs2_addr_i = AW'(a);
            #1;
            check("midrst_rs1_busy", rs1_busy_o, 1'b0);
            check("midrst_rs2_busy", rs2_busy_o, 1'b0);
        end
        ex_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(AW'(12), AW'(3));
        step(0, '0, '0, 1, AW'(4), 32'h44444444, 0, '0, '0, '0);
        step(1, AW'(6), 32'h66666666, 1, AW'(8), 32'h88888888, 0, '0, '0, '0);
        step(1, AW'(6), 32'h66660001, 1, AW'(8), 32'h88880001, 0, '0, '0, '0);
        repeat (3) idle('0, '0);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
